// File: rtl/fifo_asym_if.sv
// fifo_asym_if: write/read handshake and status bundle for fifo_asym.
// The master drives requests and write data; the slave (FIFO) returns read data and flags.
interface fifo_asym_if #(
    parameter int WR_DWIDTH = 32,
    parameter int RD_DWIDTH = 8,
    parameter int AWIDTH    = 4
);
    logic [WR_DWIDTH-1:0] din;
    logic                 w_en;
    logic [RD_DWIDTH-1:0] dout;
    logic                 r_en;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [AWIDTH:0]      level;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output din, w_en, r_en,
        input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  din, w_en, r_en,
        output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_asym.sv
// fifo_asym: single-clock FIFO with power-of-two write/read width ratio, fill level,
// almost-full/almost-empty thresholds and overflow/underflow pulses.
module fifo_asym #(
    parameter int WR_DWIDTH = 32,
    parameter int RD_DWIDTH = 8,
    parameter int AWIDTH    = 4,
    parameter int AF_LEVEL  = 2**AWIDTH-4,
    parameter int AE_LEVEL  = 4
) (
    input logic        clk,
    input logic        rstn,
    fifo_asym_if.slave bus
);
    localparam int NARROW   = WR_DWIDTH < RD_DWIDTH ? WR_DWIDTH : RD_DWIDTH;
    localparam int WIDE     = WR_DWIDTH < RD_DWIDTH ? RD_DWIDTH : WR_DWIDTH;
    localparam int RATIO    = WIDE / NARROW;
    localparam int WR_UNITS = WR_DWIDTH / NARROW;
    localparam int RD_UNITS = RD_DWIDTH / NARROW;
    localparam int DEPTH    = 2**AWIDTH;
    localparam int LWU      = $clog2(WR_UNITS);
    localparam int ROWS     = DEPTH / WR_UNITS;
    localparam int ROWW     = AWIDTH - LWU;

    localparam logic [AWIDTH:0]   WU_C    = (AWIDTH+1)'(WR_UNITS);
    localparam logic [AWIDTH:0]   RU_C    = (AWIDTH+1)'(RD_UNITS);
    localparam logic [AWIDTH:0]   FULL_TH = (AWIDTH+1)'(DEPTH - WR_UNITS);
    localparam logic [AWIDTH:0]   AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0]   AE_C    = (AWIDTH+1)'(AE_LEVEL);
    localparam logic [AWIDTH-1:0] LANE_M  = AWIDTH'(WR_UNITS - 1);

    if ((WIDE % NARROW) != 0 || (RATIO & (RATIO - 1)) != 0 || DEPTH < 2 * RATIO) begin : g_bad_cfg
        $error("fifo_asym: illegal width ratio or depth");
    end

    // Rows hold one write word, so every accepted write is a single aligned row store
    logic [WR_DWIDTH-1:0] mem [ROWS];

    logic [AWIDTH:0]      wr_q, wr_d, rd_q, rd_d, level;
    logic [RD_DWIDTH-1:0] dout_q, dout_d, rd_word;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 full, empty, wr_ok, rd_ok;
    logic [AWIDTH-1:0]    a;

    always_comb begin
        level  = wr_q - rd_q;
        full   = level > FULL_TH;
        empty  = level < RU_C;
        wr_ok  = bus.w_en && !full;
        rd_ok  = bus.r_en && !empty;
        wr_d   = wr_ok ? wr_q + WU_C : wr_q;
        rd_d   = rd_ok ? rd_q + RU_C : rd_q;
        ovf_d  = bus.w_en && full;
        unf_d  = bus.r_en && empty;
        dout_d = rd_ok ? rd_word : dout_q;
    end

    // Gather RD_UNITS consecutive narrow slices, oldest in the low bits
    always_comb begin
        rd_word = '0;
        a       = '0;
        for (int i = 0; i < RD_UNITS; i++) begin
            a = rd_q[AWIDTH-1:0] + AWIDTH'(i);
            rd_word[i*NARROW +: NARROW] = mem[ROWW'(a >> LWU)][(a & LANE_M) * NARROW +: NARROW];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_q[AWIDTH-1:LWU]] <= bus.din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = level >= AF_C;
    assign bus.almost_empty = level <= AE_C;
    assign bus.level        = level;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_asym.sv
// tb_fifo_asym: drives a 32->8 and an 8->32 fifo_asym side by side against
// byte-queue models, plus directed vectors with hand-computed expectations.
module tb_fifo_asym;
    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    fifo_asym_if #(.WR_DWIDTH(32), .RD_DWIDTH(8),  .AWIDTH(4)) a ();
    fifo_asym_if #(.WR_DWIDTH(8),  .RD_DWIDTH(32), .AWIDTH(4)) b ();

    fifo_asym #(.WR_DWIDTH(32), .RD_DWIDTH(8),  .AWIDTH(4)) u_a (.clk(clk), .rstn(rstn), .bus(a));
    fifo_asym #(.WR_DWIDTH(8),  .RD_DWIDTH(32), .AWIDTH(4)) u_b (.clk(clk), .rstn(rstn), .bus(b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Models: FIFO contents as a queue of bytes, widths handled by plain push/pop
    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [7:0]  eda = '0;
    logic [31:0] edb = '0;
    logic        eoa = 0, eua = 0, eob = 0, eub = 0;
    logic        fa, ea, fb, eb;
    int          wa = 0, wb = 0;

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            qa.delete(); qb.delete();
            eda = '0; edb = '0; eoa = 0; eua = 0; eob = 0; eub = 0;
        end else begin
            fa = (16 - qa.size()) < 4;
            ea = qa.size() < 1;
            fb = (16 - qb.size()) < 1;
            eb = qb.size() < 4;
            eoa = a.w_en && fa;
            eua = a.r_en && ea;
            eob = b.w_en && fb;
            eub = b.r_en && eb;
            if (a.r_en && !ea) eda = qa.pop_front();
            if (a.w_en && !fa) begin
                for (int i = 0; i < 4; i++) qa.push_back(a.din[i*8 +: 8]);
                wa++;
            end
            if (b.r_en && !eb) for (int i = 0; i < 4; i++) edb[i*8 +: 8] = qb.pop_front();
            if (b.w_en && !fb) begin
                qb.push_back(b.din);
                wb++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_dout",  32'(a.dout), 32'(eda));
        chk("a_level", 32'(a.level), qa.size());
        chk("a_full",  32'(a.full), 32'((16 - qa.size()) < 4));
        chk("a_empty", 32'(a.empty), 32'(qa.size() < 1));
        chk("a_af",    32'(a.almost_full), 32'(qa.size() >= 12));
        chk("a_ae",    32'(a.almost_empty), 32'(qa.size() <= 4));
        chk("a_ovf",   32'(a.overflow), 32'(eoa));
        chk("a_unf",   32'(a.underflow), 32'(eua));
        chk("b_dout",  b.dout, edb);
        chk("b_level", 32'(b.level), qb.size());
        chk("b_full",  32'(b.full), 32'(qb.size() >= 16));
        chk("b_empty", 32'(b.empty), 32'(qb.size() < 4));
        chk("b_af",    32'(b.almost_full), 32'(qb.size() >= 12));
        chk("b_ae",    32'(b.almost_empty), 32'(qb.size() <= 4));
        chk("b_ovf",   32'(b.overflow), 32'(eob));
        chk("b_unf",   32'(b.underflow), 32'(eub));
    endtask

    initial forever begin
        @(negedge clk);
        check_all();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cyc;
    int ph;

    initial begin
        rstn = 1'b0;
        a.din = '0; a.w_en = 0; a.r_en = 0;
        b.din = '0; b.w_en = 0; b.r_en = 0;
        repeat (2) tick();
        chk("rst_a_level", 32'(a.level), 0);
        chk("rst_a_empty", 32'(a.empty), 1);
        chk("rst_a_ae",    32'(a.almost_empty), 1);
        rstn = 1'b1;

        // 32->8: one word out as four bytes
        a.din = 32'h44332211; a.w_en = 1; tick(); a.w_en = 0;
        chk("t1_level", 32'(a.level), 4);
        a.r_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_dout", 32'(a.dout), 32'(8'h11 * (i + 1)));
            chk("t1_level", 32'(a.level), 3 - i);
        end
        a.r_en = 0;
        chk("t1_empty", 32'(a.empty), 1);

        // 32->8: fill, reject a fifth word, data intact
        a.w_en = 1;
        for (int w = 0; w < 4; w++) begin
            a.din = 32'h03020100 + 32'(w) * 32'h04040404;
            tick();
        end
        a.w_en = 0;
        chk("t2_full", 32'(a.full), 1);
        chk("t2_level", 32'(a.level), 16);
        a.din = 32'hDEADBEEF; a.w_en = 1; tick(); a.w_en = 0;
        chk("t2_ovf", 32'(a.overflow), 1);
        chk("t2_level", 32'(a.level), 16);
        tick();
        chk("t2_ovf_drop", 32'(a.overflow), 0);
        a.r_en = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_dout", 32'(a.dout), i);
        end
        a.r_en = 0;
        chk("t2_empty", 32'(a.empty), 1);

        // 8->32: partial word is not readable
        b.w_en = 1;
        b.din = 8'hAA; tick();
        b.din = 8'hBB; tick();
        b.din = 8'hCC; tick();
        b.w_en = 0;
        chk("t3_empty", 32'(b.empty), 1);
        b.r_en = 1; tick(); b.r_en = 0;
        chk("t3_unf", 32'(b.underflow), 1);
        chk("t3_dout_hold", b.dout, 0);
        b.din = 8'hDD; b.w_en = 1; tick(); b.w_en = 0;
        chk("t3_empty_fall", 32'(b.empty), 0);
        b.r_en = 1; tick(); b.r_en = 0;
        chk("t3_dout", b.dout, 32'hDDCCBBAA);
        chk("t3_level", 32'(b.level), 0);

        // 32->8: simultaneous read/write at level 12 and at full
        a.w_en = 1;
        for (int w = 0; w < 3; w++) begin
            a.din = 32'h10000000 + 32'(w);
            tick();
        end
        chk("t4_level12", 32'(a.level), 12);
        a.din = 32'hCAFEF00D; a.r_en = 1; tick();
        a.w_en = 0; a.r_en = 0;
        chk("t4_level15", 32'(a.level), 15);
        a.r_en = 1; repeat (3) tick(); a.r_en = 0;
        a.din = 32'h55667788; a.w_en = 1; tick(); a.w_en = 0;
        chk("t4_level16", 32'(a.level), 16);
        a.din = 32'h99999999; a.w_en = 1; a.r_en = 1; tick();
        a.w_en = 0; a.r_en = 0;
        chk("t4_ovf", 32'(a.overflow), 1);
        chk("t4_level_after", 32'(a.level), 15);
        a.r_en = 1; repeat (15) tick(); a.r_en = 0;
        chk("t4_empty", 32'(a.empty), 1);

        // Random streaming through both FIFOs, alternating fill/drain phases
        wa = 0; wb = 0; cyc = 0;
        while ((wa < 1000 || wb < 1000) && cyc < 20000) begin
            ph = (cyc / 150) % 2;
            a.w_en = $urandom_range(0, 99) < (ph != 0 ? 60 : 10);
            a.r_en = $urandom_range(0, 99) < 70;
            a.din  = $urandom();
            b.w_en = $urandom_range(0, 99) < (ph != 0 ? 90 : 40);
            b.r_en = $urandom_range(0, 99) < (ph != 0 ? 10 : 40);
            b.din  = 8'($urandom());
            tick();
            cyc++;
        end
        chk("stream_budget", 32'(wa >= 1000 && wb >= 1000), 1);

        // Keep some data in flight, then reset between edges
        a.w_en = 1; a.r_en = 0; b.w_en = 1; b.r_en = 0;
        repeat (3) tick();
        a.w_en = 0; b.w_en = 0;
        #3;
        rstn = 1'b0;
        #1;
        chk("mrst_a_level", 32'(a.level), 0);
        chk("mrst_a_empty", 32'(a.empty), 1);
        chk("mrst_a_full",  32'(a.full), 0);
        chk("mrst_a_dout",  32'(a.dout), 0);
        chk("mrst_a_af",    32'(a.almost_full), 0);
        chk("mrst_b_level", 32'(b.level), 0);
        chk("mrst_b_dout",  b.dout, 0);
        check_all();
        tick();
        rstn = 1'b1;
        a.din = 32'h44332211; a.w_en = 1; tick(); a.w_en = 0;
        a.r_en = 1; tick(); a.r_en = 0;
        chk("post_dout", 32'(a.dout), 32'h11);
        chk("post_level", 32'(a.level), 3);
        a.r_en = 1; repeat (3) tick(); a.r_en = 0;
        chk("post_dout_last", 32'(a.dout), 32'h44);
        chk("post_empty", 32'(a.empty), 1);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
